id_stage: RTL and testbench



---
 rtl/id_stage_pkg.sv | 118 +++++++++++
 rtl/id_stage_regfile.sv | 28 ++
 rtl/id_stage.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: bus widths, ALU op indices,
// opcode constants and the packed bus layouts exchanged with neighbours.
package id_stage_pkg;

    // Bus widths
    localparam int FS_DS_W  = 64;
    localparam int BR_W     = 34;
    localparam int DS_ES_W  = 150;
    localparam int WS_RF_W  = 38;

    localparam int RF_DEPTH = 32;
    localparam int ALU_OP_W = 12;

    // One-hot ALU op bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_NOR  = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // Opcode constants, named by the number of leading instruction bits compared
    localparam logic [16:0] OP17_ADD_W   = 17'h00020;
    localparam logic [9:0]  OP10_ADDI_W  = 10'h00A;
    localparam logic [9:0]  OP10_LD_W    = 10'h0A2;
    localparam logic [9:0]  OP10_ST_W    = 10'h0A6;
    localparam logic [6:0]  OP7_LU12I_W  = 7'h0A;
    localparam logic [5:0]  OP6_JIRL     = 6'h13;
    localparam logic [5:0]  OP6_B        = 6'h14;
    localparam logic [5:0]  OP6_BL       = 6'h15;
    localparam logic [5:0]  OP6_BEQ      = 6'h16;
    localparam logic [5:0]  OP6_BNE      = 6'h17;

    // Link register used by bl
    localparam logic [4:0]  REG_RA       = 5'd1;

    typedef enum logic [3:0] {
        INST_NOP,
        INST_ADD_W,
        INST_ADDI_W,
        INST_LU12I_W,
        INST_LD_W,
        INST_ST_W,
        INST_JIRL,
        INST_B,
        INST_BL,
        INST_BEQ,
        INST_BNE
    } inst_kind_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_ALWAYS,
        BR_EQ,
        BR_NE
    } br_kind_t;

    typedef enum logic [1:0] {
        TGT_PC_OFFS16,
        TGT_PC_OFFS26,
        TGT_RJ_OFFS16
    } tgt_sel_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_ds_bus_t;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } ws_rf_bus_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                load_op;
        logic                mem_we;
        logic                src1_is_pc;
        logic                src2_is_imm;
        logic                gr_we;
        logic [4:0]          dest;
        logic [31:0]         imm;
        logic [31:0]         rj_value;
        logic [31:0]         rkd_value;
        logic [31:0]         pc;
    } ds_es_bus_t;

    // Classify an instruction word; anything unrecognised is a NOP
    function automatic inst_kind_t classify(input logic [31:0] inst);
        inst_kind_t kind;
        kind = INST_NOP;
        if (inst[31:15] == OP17_ADD_W)        kind = INST_ADD_W;
        else if (inst[31:22] == OP10_ADDI_W)  kind = INST_ADDI_W;
        else if (inst[31:25] == OP7_LU12I_W)  kind = INST_LU12I_W;
        else if (inst[31:22] == OP10_LD_W)    kind = INST_LD_W;
        else if (inst[31:22] == OP10_ST_W)    kind = INST_ST_W;
        else if (inst[31:26] == OP6_JIRL)     kind = INST_JIRL;
        else if (inst[31:26] == OP6_B)        kind = INST_B;
        else if (inst[31:26] == OP6_BL)       kind = INST_BL;
        else if (inst[31:26] == OP6_BEQ)      kind = INST_BEQ;
        else if (inst[31:26] == OP6_BNE)      kind = INST_BNE;
        return kind;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 general register file: two combinational read ports, one
// synchronous write port. r0 reads as zero and is never written.
module id_stage_regfile
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] rf_mem [RF_DEPTH];

    // Write port; r0 is hardwired so writes to it are discarded
    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            rf_mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf_mem[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf_mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: holds one instruction from fetch, decodes it, reads the
// register file, interlocks on RAW hazards, resolves branches and hands a
// decoded bundle to execute.
module id_stage
    import id_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               fs_to_ds_valid,
    input  logic [FS_DS_W-1:0] fs_to_ds_bus,
    output logic               ds_allowin,
    output logic [BR_W-1:0]    br_bus,
    input  logic               es_allowin,
    output logic               ds_to_es_valid,
    output logic [DS_ES_W-1:0] ds_to_es_bus,
    input  logic [5:0]         es_dest,
    input  logic [5:0]         ms_dest,
    input  logic [5:0]         ws_dest,
    input  logic [WS_RF_W-1:0] ws_to_rf_bus
);

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic       ds_valid_reg;
    fs_ds_bus_t ds_bus_reg;
    logic       ds_ready_go;
    logic       br_taken;
    logic       br_stall;

    // Valid bit: refilled whenever decode can accept; a taken branch drops
    // the fall-through instruction arriving in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_reg <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid_reg <= fs_to_ds_valid && !br_taken;
        end
    end

    // Instruction/pc capture from fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_bus_reg <= '0;
        end else if (ds_allowin && fs_to_ds_valid) begin
            ds_bus_reg <= fs_ds_bus_t'(fs_to_ds_bus);
        end
    end

    logic [31:0] inst;
    logic [31:0] pc;
    assign inst = ds_bus_reg.inst;
    assign pc   = ds_bus_reg.pc;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic [31:0] si12;
    logic [31:0] si20;
    logic [31:0] offs16;
    logic [31:0] offs26;

    assign rd     = inst[4:0];
    assign rj     = inst[9:5];
    assign rk     = inst[14:10];
    assign si12   = {{20{inst[21]}}, inst[21:10]};
    assign si20   = {inst[24:5], 12'b0};
    assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b0};
    assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b0};

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    inst_kind_t          kind;
    logic [ALU_OP_W-1:0] alu_op;
    logic                load_op;
    logic                mem_we;
    logic                src1_is_pc;
    logic                src2_is_imm;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         imm;
    logic                use_rj;
    logic                use_rkd;
    logic                rkd_is_rd;
    logic                is_branch;
    br_kind_t            br_kind;
    tgt_sel_t            tgt_sel;

    assign kind = classify(inst);

    // Translate the instruction class into datapath controls
    always_comb begin
        alu_op      = '0;
        load_op     = 1'b0;
        mem_we      = 1'b0;
        src1_is_pc  = 1'b0;
        src2_is_imm = 1'b0;
        gr_we       = 1'b0;
        dest        = rd;
        imm         = 32'd0;
        use_rj      = 1'b0;
        use_rkd     = 1'b0;
        rkd_is_rd   = 1'b0;
        is_branch   = 1'b0;
        br_kind     = BR_NONE;
        tgt_sel     = TGT_PC_OFFS16;
        case (kind)
            INST_ADD_W: begin
                alu_op[ALU_ADD] = 1'b1;
                gr_we           = 1'b1;
                use_rj          = 1'b1;
                use_rkd         = 1'b1;
            end
            INST_ADDI_W: begin
                alu_op[ALU_ADD] = 1'b1;
                src2_is_imm     = 1'b1;
                imm             = si12;
                gr_we           = 1'b1;
                use_rj          = 1'b1;
            end
            INST_LU12I_W: begin
                alu_op[ALU_LUI] = 1'b1;
                src2_is_imm     = 1'b1;
                imm             = si20;
                gr_we           = 1'b1;
            end
            INST_LD_W: begin
                alu_op[ALU_ADD] = 1'b1;
                load_op         = 1'b1;
                src2_is_imm     = 1'b1;
                imm             = si12;
                gr_we           = 1'b1;
                use_rj          = 1'b1;
            end
            INST_ST_W: begin
                alu_op[ALU_ADD] = 1'b1;
                mem_we          = 1'b1;
                src2_is_imm     = 1'b1;
                imm             = si12;
                use_rj          = 1'b1;
                use_rkd         = 1'b1;
                rkd_is_rd       = 1'b1;
            end
            INST_JIRL: begin
                // Link value pc+4 is formed in execute as pc + imm
                alu_op[ALU_ADD] = 1'b1;
                src1_is_pc      = 1'b1;
                src2_is_imm     = 1'b1;
                imm             = 32'd4;
                gr_we           = 1'b1;
                use_rj          = 1'b1;
                is_branch       = 1'b1;
                br_kind         = BR_ALWAYS;
                tgt_sel         = TGT_RJ_OFFS16;
            end
            INST_B: begin
                is_branch = 1'b1;
                br_kind   = BR_ALWAYS;
                tgt_sel   = TGT_PC_OFFS26;
            end
            INST_BL: begin
                alu_op[ALU_ADD] = 1'b1;
                src1_is_pc      = 1'b1;
                src2_is_imm     = 1'b1;
                imm             = 32'd4;
                gr_we           = 1'b1;
                dest            = REG_RA;
                is_branch       = 1'b1;
                br_kind         = BR_ALWAYS;
                tgt_sel         = TGT_PC_OFFS26;
            end
            INST_BEQ: begin
                use_rj    = 1'b1;
                use_rkd   = 1'b1;
                rkd_is_rd = 1'b1;
                is_branch = 1'b1;
                br_kind   = BR_EQ;
            end
            INST_BNE: begin
                use_rj    = 1'b1;
                use_rkd   = 1'b1;
                rkd_is_rd = 1'b1;
                is_branch = 1'b1;
                br_kind   = BR_NE;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    ws_rf_bus_t  ws_rf;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;

    assign ws_rf     = ws_rf_bus_t'(ws_to_rf_bus);
    assign rf_raddr1 = rj;
    assign rf_raddr2 = rkd_is_rd ? rd : rk;

    id_stage_regfile u_regfile (
        .clk    (clk),
        .raddr1 (rf_raddr1),
        .rdata1 (rj_value),
        .raddr2 (rf_raddr2),
        .rdata2 (rkd_value),
        .we     (ws_rf.we),
        .waddr  (ws_rf.waddr),
        .wdata  (ws_rf.wdata)
    );

    // ------------------------------------------------------------------
    // RAW interlock: any younger-stage writer of a used source stalls,
    // including writeback because the register file has no bypass
    // ------------------------------------------------------------------
    logic [5:0] stage_dest [3];
    logic [2:0] rj_hit;
    logic [2:0] rkd_hit;
    logic       hazard;

    assign stage_dest[0] = es_dest;
    assign stage_dest[1] = ms_dest;
    assign stage_dest[2] = ws_dest;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hazard
            assign rj_hit[gi]  = stage_dest[gi][5] && (stage_dest[gi][4:0] == rf_raddr1);
            assign rkd_hit[gi] = stage_dest[gi][5] && (stage_dest[gi][4:0] == rf_raddr2);
        end
    endgenerate

    assign hazard = (use_rj  && (rf_raddr1 != 5'd0) && (|rj_hit)) ||
                    (use_rkd && (rf_raddr2 != 5'd0) && (|rkd_hit));

    assign ds_ready_go = !hazard;

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    logic [31:0] br_target_calc;
    logic        br_cond;

    // Compute target address and condition outcome
    always_comb begin
        case (tgt_sel)
            TGT_PC_OFFS26: br_target_calc = pc + offs26;
            TGT_RJ_OFFS16: br_target_calc = rj_value + offs16;
            default:       br_target_calc = pc + offs16;
        endcase
        case (br_kind)
            BR_ALWAYS: br_cond = 1'b1;
            BR_EQ:     br_cond = (rj_value == rkd_value);
            BR_NE:     br_cond = (rj_value != rkd_value);
            default:   br_cond = 1'b0;
        endcase
    end

    assign br_taken = ds_valid_reg && ds_ready_go && es_allowin && br_cond;
    assign br_stall = ds_valid_reg && is_branch && !ds_ready_go;

    br_bus_t br_out;
    assign br_out.stall  = br_stall;
    assign br_out.taken  = br_taken;
    assign br_out.target = (ds_valid_reg && is_branch) ? br_target_calc : 32'd0;
    assign br_bus        = br_out;

    // ------------------------------------------------------------------
    // Handshake and outgoing bundle
    // ------------------------------------------------------------------
    assign ds_allowin     = !ds_valid_reg || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid_reg && ds_ready_go;

    ds_es_bus_t es_out;
    assign es_out.alu_op      = alu_op;
    assign es_out.load_op     = load_op;
    assign es_out.mem_we      = mem_we;
    assign es_out.src1_is_pc  = src1_is_pc;
    assign es_out.src2_is_imm = src2_is_imm;
    assign es_out.gr_we       = gr_we;
    assign es_out.dest        = dest;
    assign es_out.imm         = imm;
    assign es_out.rj_value    = rj_value;
    assign es_out.rkd_value   = rkd_value;
    assign es_out.pc          = pc;
    assign ds_to_es_bus       = es_out;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: drives fetch/writeback/hazard inputs step by
// step and checks handshake, decoded fields and branch bus after each edge.
module tb_id_stage;

    logic         clk;
    logic         reset;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic [33:0]  br_bus;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic [5:0]   es_dest;
    logic [5:0]   ms_dest;
    logic [5:0]   ws_dest;
    logic [37:0]  ws_to_rf_bus;

    int total;
    int bad;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_dest        (es_dest),
        .ms_dest        (ms_dest),
        .ws_dest        (ws_dest),
        .ws_to_rf_bus   (ws_to_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed fields, widened so every comparison is 32 bits
    logic [31:0] o_valid, o_allowin, o_stall, o_taken, o_target;
    logic [31:0] o_alu, o_load, o_mem_we, o_src1_pc, o_src2_imm, o_gr_we;
    logic [31:0] o_dest, o_imm, o_rj, o_rkd, o_pc;
    assign o_valid    = 32'(ds_to_es_valid);
    assign o_allowin  = 32'(ds_allowin);
    assign o_stall    = 32'(br_bus[33]);
    assign o_taken    = 32'(br_bus[32]);
    assign o_target   = br_bus[31:0];
    assign o_alu      = 32'(ds_to_es_bus[149:138]);
    assign o_load     = 32'(ds_to_es_bus[137]);
    assign o_mem_we   = 32'(ds_to_es_bus[136]);
    assign o_src1_pc  = 32'(ds_to_es_bus[135]);
    assign o_src2_imm = 32'(ds_to_es_bus[134]);
    assign o_gr_we    = 32'(ds_to_es_bus[133]);
    assign o_dest     = 32'(ds_to_es_bus[132:128]);
    assign o_imm      = ds_to_es_bus[127:96];
    assign o_rj       = ds_to_es_bus[95:64];
    assign o_rkd      = ds_to_es_bus[63:32];
    assign o_pc       = ds_to_es_bus[31:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs settle and outputs are read 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge, then withdraw it
    task automatic feed(input logic [31:0] f_pc, input logic [31:0] f_inst);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {f_pc, f_inst};
        step();
        fs_to_ds_valid = 1'b0;
        #1;
        $display("txn pc=%08h inst=%08h valid=%0d allowin=%0d br=%09h",
                 f_pc, f_inst, ds_to_es_valid, ds_allowin, br_bus);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        es_allowin     = 1'b1;
        es_dest        = '0;
        ms_dest        = '0;
        ws_dest        = '0;
        ws_to_rf_bus   = '0;

        // Reset for three cycles
        step(); step(); step();
        check("rst_valid",   o_valid,   32'd0);
        check("rst_br_bus",  {o_stall[0], o_taken[0], o_target[29:0]}, 32'd0);
        check("rst_allowin", o_allowin, 32'd1);
        reset = 1'b0;

        // addi.w r4,r0,5
        feed(32'h1C000000, 32'h02801404);
        check("addi_valid", o_valid,    32'd1);
        check("addi_dest",  o_dest,     32'd4);
        check("addi_imm",   o_imm,      32'd5);
        check("addi_grwe",  o_gr_we,    32'd1);
        check("addi_alu",   o_alu,      32'h001);
        check("addi_src2",  o_src2_imm, 32'd1);
        check("addi_pc",    o_pc,       32'h1C000000);
        step();
        check("addi_drain", o_valid,    32'd0);

        // Writeback puts 5 into r4
        ws_to_rf_bus = {1'b1, 5'd4, 32'd5};
        step();
        ws_to_rf_bus = '0;

        // beq r0,r0,+8 with fall-through waiting in fetch
        feed(32'h1C000010, 32'h58000800);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {32'h1C000014, 32'h02800C07};
        #1;
        check("beq_taken",  o_taken,  32'd1);
        check("beq_target", o_target, 32'h1C000018);
        check("beq_stall",  o_stall,  32'd0);
        step();
        check("squash_valid", o_valid, 32'd0);
        check("squash_taken", o_taken, 32'd0);
        fs_to_ds_bus = {32'h1C000018, 32'h02800C07};
        step();
        fs_to_ds_valid = 1'b0;
        #1;
        check("target_valid", o_valid, 32'd1);
        check("target_pc",    o_pc,    32'h1C000018);
        step();

        // add.w r5,r4,r4 with r4 pending in execute, then memory, then writeback
        es_dest = {1'b1, 5'd4};
        feed(32'h1C000020, 32'h00101085);
        check("raw_es_valid",   o_valid,   32'd0);
        check("raw_es_allowin", o_allowin, 32'd0);
        es_dest = '0;
        ms_dest = {1'b1, 5'd4};
        step();
        check("raw_ms_valid",   o_valid,   32'd0);
        ms_dest = '0;
        ws_dest = {1'b1, 5'd4};
        step();
        check("raw_ws_valid",   o_valid,   32'd0);
        check("raw_ws_allowin", o_allowin, 32'd0);
        ws_dest = '0;
        #1;
        check("raw_go_valid", o_valid, 32'd1);
        check("raw_go_rj",    o_rj,    32'd5);
        check("raw_go_rkd",   o_rkd,   32'd5);
        check("raw_go_dest",  o_dest,  32'd5);
        step();
        check("raw_drain", o_valid, 32'd0);

        // bne r4,r0,+16 with r4 pending in memory
        ms_dest = {1'b1, 5'd4};
        feed(32'h1C000024, 32'h5C001080);
        check("bne_stall",   o_stall, 32'd1);
        check("bne_notaken", o_taken, 32'd0);
        step();
        check("bne_stall2",  o_stall, 32'd1);
        ms_dest = '0;
        #1;
        check("bne_go_stall",  o_stall,  32'd0);
        check("bne_go_taken",  o_taken,  32'd1);
        check("bne_go_target", o_target, 32'h1C000034);
        check("bne_go_rj",     o_rj,     32'd5);
        step();

        // beq r4,r0,+8 falls through since r4=5
        feed(32'h1C000034, 32'h58000880);
        check("beq_nt_taken", o_taken, 32'd0);
        check("beq_nt_valid", o_valid, 32'd1);
        step();

        // Writes to r0 are discarded; add.w r6,r0,r0 reads zero
        ws_to_rf_bus = {1'b1, 5'd0, 32'hFFFFFFFF};
        step();
        ws_to_rf_bus = '0;
        feed(32'h1C000038, 32'h00100006);
        check("r0_rj",  o_rj,  32'd0);
        check("r0_rkd", o_rkd, 32'd0);
        step();

        // bl +0x40 at 0x1C000100
        feed(32'h1C000100, 32'h54004000);
        check("bl_dest",   o_dest,    32'd1);
        check("bl_imm",    o_imm,     32'd4);
        check("bl_src1pc", o_src1_pc, 32'd1);
        check("bl_grwe",   o_gr_we,   32'd1);
        check("bl_taken",  o_taken,   32'd1);
        check("bl_target", o_target,  32'h1C000140);
        step();

        // b -4: negative 26-bit offset
        feed(32'h1C000200, 32'h53FFFFFF);
        check("b_taken",  o_taken,  32'd1);
        check("b_target", o_target, 32'h1C0001FC);
        check("b_grwe",   o_gr_we,  32'd0);
        step();

        // jirl r0,r4,+8: target from register value
        feed(32'h1C000204, 32'h4C000880);
        check("jirl_taken",  o_taken,  32'd1);
        check("jirl_target", o_target, 32'h0000000D);
        step();

        // lu12i.w r8,0x12345
        feed(32'h1C000208, 32'h142468A8);
        check("lui_alu",  o_alu,  32'h800);
        check("lui_imm",  o_imm,  32'h12345000);
        check("lui_dest", o_dest, 32'd8);
        step();

        // st.w r4,r0,0x10: rd read as second source
        feed(32'h1C00020C, 32'h29804004);
        check("st_memwe", o_mem_we, 32'd1);
        check("st_grwe",  o_gr_we,  32'd0);
        check("st_rkd",   o_rkd,    32'd5);
        check("st_imm",   o_imm,    32'h10);
        step();

        // ld.w r9,r4,-4
        feed(32'h1C000210, 32'h28BFF089);
        check("ld_load", o_load, 32'd1);
        check("ld_imm",  o_imm,  32'hFFFFFFFC);
        check("ld_rj",   o_rj,   32'd5);
        step();

        // Unknown encoding decodes as NOP
        feed(32'h1C000214, 32'hFFFFFFFF);
        check("nop_grwe",  o_gr_we,  32'd0);
        check("nop_memwe", o_mem_we, 32'd0);
        check("nop_taken", o_taken,  32'd0);
        step();

        // Execute back-pressure holds the bundle; reset in cycle 2
        es_allowin     = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {32'h1C000300, 32'h02801404};
        step();
        fs_to_ds_bus   = {32'h1C000304, 32'h142468A8};
        #1;
        check("hold1_valid",   o_valid,   32'd1);
        check("hold1_allowin", o_allowin, 32'd0);
        check("hold1_pc",      o_pc,      32'h1C000300);
        step();
        check("hold2_pc",      o_pc,      32'h1C000300);
        check("hold2_imm",     o_imm,     32'd5);
        check("hold2_allowin", o_allowin, 32'd0);
        reset = 1'b1;
        step();
        check("hold_rst_valid", o_valid, 32'd0);
        check("hold_rst_br",    o_target | o_taken | o_stall, 32'd0);
        reset          = 1'b0;
        fs_to_ds_valid = 1'b0;
        es_allowin     = 1'b1;
        step();

        // Reset while a branch is stalled on a hazard
        ms_dest = {1'b1, 5'd4};
        feed(32'h1C000400, 32'h5C001080);
        check("rst_stall_pre", o_stall, 32'd1);
        reset = 1'b1;
        step();
        check("rst_stall_br",    o_target | o_taken | o_stall, 32'd0);
        check("rst_stall_valid", o_valid, 32'd0);
        reset   = 1'b0;
        ms_dest = '0;
        step();
        check("rst_stall_allowin", o_allowin, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
